mda_pixel_serializer: RTL and testbench

MDA_PIXEL_SERIALIZER -- requirements
Module: mda_pixel_serializer

---
 rtl/mda_pixel_serializer_pkg.sv | 43 ++++
 rtl/mda_pixel_serializer_if.sv | 31 +++
 rtl/mda_blink_counter.sv | 37 +++
 rtl/mda_pixel_serializer.sv | 99 +++++++++
 tb/tb_mda_pixel_serializer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mda_pixel_serializer_pkg.sv
// Shared MDA video definitions: attribute decode constants,
// line-graphics code range and the latched per-cell bundle.
package mda_pixel_serializer_pkg;

    localparam logic [7:0] ATTR_MASK      = 8'h77;
    localparam logic [7:0] ATTR_BLANK     = 8'h00;
    localparam logic [7:0] ATTR_REVERSE   = 8'h70;
    localparam logic [7:0] ATTR_UNDERLINE = 8'h01;
    localparam logic [7:0] LG_FIRST       = 8'hC0;
    localparam logic [7:0] LG_LAST        = 8'hDF;

    typedef enum logic [1:0] {
        ATTR_NORMAL,
        ATTR_BLANKED,
        ATTR_REVERSED,
        ATTR_UNDERLINED
    } attr_kind_e;

    typedef struct packed {
        logic [7:0] attr;
        logic [4:0] row_addr;
        logic       cursor_here;
        logic       display_en;
    } cell_t;

    function automatic attr_kind_e attr_kind(input logic [7:0] a);
        logic [7:0] m;
        attr_kind_e k;
        m = a & ATTR_MASK;
        unique case (1'b1)
            (m == ATTR_BLANK):     k = ATTR_BLANKED;
            (m == ATTR_REVERSE):   k = ATTR_REVERSED;
            (m == ATTR_UNDERLINE): k = ATTR_UNDERLINED;
            default:               k = ATTR_NORMAL;
        endcase
        return k;
    endfunction

    function automatic logic is_line_graphics(input logic [7:0] code);
        return (code >= LG_FIRST) && (code <= LG_LAST);
    endfunction

endpackage

// File: rtl/mda_pixel_serializer_if.sv
// Character-cell inputs and pixel outputs of the MDA serializer.
// The master side is the CRTC/font fetch logic, the slave the serializer.
interface mda_pixel_serializer_if;
    import mda_pixel_serializer_pkg::*;

    logic       pix_ce;
    logic       char_load;
    logic [7:0] char_code;
    logic [7:0] attr;
    logic [7:0] font_row;
    logic [4:0] row_addr;
    logic       cursor_here;
    logic       display_en;
    logic       blink_en;
    logic       vsync;
    logic       video;
    logic       intensity;

    modport master (
        output pix_ce, char_load, char_code, attr, font_row, row_addr,
        output cursor_here, display_en, blink_en, vsync,
        input  video, intensity
    );

    modport slave (
        input  pix_ce, char_load, char_code, attr, font_row, row_addr,
        input  cursor_here, display_en, blink_en, vsync,
        output video, intensity
    );

endinterface

// File: rtl/mda_blink_counter.sv
// Counts vsync rising edges in a 5-bit wrapping frame counter;
// bit 3 paces the cursor blink and bit 4 the character blink.
module mda_blink_counter
    import mda_pixel_serializer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vsync,
    output logic [4:0] count
);

    logic       vsync_q;
    logic       vsync_d;
    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    always_comb begin
        vsync_d = vsync;
        cnt_d   = cnt_q;
        if (vsync && !vsync_q) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vsync_q <= vsync_d;
            cnt_q   <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/mda_pixel_serializer.sv
// 9-dot MDA character serializer: font shift register, attribute
// decode, blink/cursor overlay and registered video/intensity.
module mda_pixel_serializer
    import mda_pixel_serializer_pkg::*;
#(
    parameter int UNDERLINE_ROW = 12,
    parameter bit BLANK_C0_DF   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mda_pixel_serializer_if.slave bus
);

    localparam logic [4:0] UL_ROW = 5'(UNDERLINE_ROW);

    logic [8:0] shift_q;
    logic [8:0] shift_d;
    cell_t      cell_q;
    cell_t      cell_d;
    logic       video_q;
    logic       video_d;
    logic       inten_q;
    logic       inten_d;
    logic [4:0] frame_cnt;
    logic       ninth;
    logic       pix;
    attr_kind_e kind;

    mda_blink_counter u_blink (
        .clk     (clk),
        .reset_n (reset_n),
        .vsync   (bus.vsync),
        .count   (frame_cnt)
    );

    always_comb begin
        shift_d = shift_q;
        cell_d  = cell_q;
        video_d = video_q;
        inten_d = inten_q;
        ninth   = 1'b0;
        kind    = attr_kind(cell_q.attr);
        pix     = shift_q[8];

        case (kind)
            ATTR_BLANKED:    pix = 1'b0;
            ATTR_REVERSED:   pix = ~pix;
            ATTR_UNDERLINED: if (cell_q.row_addr == UL_ROW) pix = 1'b1;
            default:         pix = shift_q[8];
        endcase

        if (bus.blink_en && cell_q.attr[7] && frame_cnt[4]) begin
            pix = 1'b0;
        end
        // Cursor goes last so it stays visible over blinking text.
        if (cell_q.cursor_here && frame_cnt[3]) begin
            pix = ~pix;
        end
        if (!cell_q.display_en) begin
            pix = 1'b0;
        end

        if (BLANK_C0_DF && is_line_graphics(bus.char_code)) begin
            ninth = bus.font_row[0];
        end

        if (bus.pix_ce) begin
            video_d = pix;
            inten_d = pix & cell_q.attr[3];
            if (bus.char_load) begin
                shift_d            = {bus.font_row, ninth};
                cell_d.attr        = bus.attr;
                cell_d.row_addr    = bus.row_addr;
                cell_d.cursor_here = bus.cursor_here;
                cell_d.display_en  = bus.display_en;
            end else begin
                shift_d = {shift_q[7:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            cell_q  <= '0;
            video_q <= 1'b0;
            inten_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cell_q  <= cell_d;
            video_q <= video_d;
            inten_q <= inten_d;
        end
    end

    assign bus.video     = video_q;
    assign bus.intensity = inten_q;

endmodule

// File: tb/tb_mda_pixel_serializer.sv
// Directed bench for mda_pixel_serializer: one cell per vector,
// nine dots collected after each load and compared to hand values.
module tb_mda_pixel_serializer;
    import mda_pixel_serializer_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    mda_pixel_serializer_if bus ();

    mda_pixel_serializer #(
        .UNDERLINE_ROW (12),
        .BLANK_C0_DF   (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_cell(input logic [7:0] code, input logic [7:0] at,
                              input logic [7:0] font, input logic [4:0] row,
                              input logic cur, input logic den);
        bus.char_code   = code;
        bus.attr        = at;
        bus.font_row    = font;
        bus.row_addr    = row;
        bus.cursor_here = cur;
        bus.display_en  = den;
        bus.char_load   = 1'b1;
    endtask

    task automatic play(input logic [7:0] code, input logic [7:0] at,
                        input logic [7:0] font, input logic [4:0] row,
                        input logic cur, input logic den,
                        output logic [8:0] v, output logic [8:0] it);
        @(negedge clk);
        drive_cell(code, at, font, row, cur, den);
        @(negedge clk);
        bus.char_load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            v[8-i]  = bus.video;
            it[8-i] = bus.intensity;
        end
    endtask

    task automatic vsync_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.vsync = 1'b1;
            @(negedge clk);
            bus.vsync = 1'b0;
        end
    endtask

    logic [8:0]  v;
    logic [8:0]  it;
    logic [17:0] v2;

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        bus.pix_ce    = 1'b1;
        bus.char_load = 1'b0;
        bus.char_code = 8'h00;
        bus.attr      = 8'h00;
        bus.font_row  = 8'h00;
        bus.row_addr  = 5'd0;
        bus.cursor_here = 1'b0;
        bus.display_en  = 1'b1;
        bus.blink_en  = 1'b0;
        bus.vsync     = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_video", 32'(bus.video), 32'd0);
        check_eq("reset_inten", 32'(bus.intensity), 32'd0);
        reset_n = 1'b1;

        play(8'h41, 8'h07, 8'h81, 5'd0, 1'b0, 1'b1, v, it);
        check_eq("a07_f81_vid", 32'(v), 32'(9'b100000010));
        check_eq("a07_f81_int", 32'(it), 32'd0);

        play(8'hC4, 8'h0F, 8'hFF, 5'd0, 1'b0, 1'b1, v, it);
        check_eq("lg_c4_vid", 32'(v), 32'h1FF);
        check_eq("lg_c4_int", 32'(it), 32'h1FF);

        play(8'h44, 8'h0F, 8'hFF, 5'd0, 1'b0, 1'b1, v, it);
        check_eq("txt_44_vid", 32'(v), 32'(9'b111111110));
        check_eq("txt_44_int", 32'(it), 32'(9'b111111110));

        play(8'h20, 8'h70, 8'h00, 5'd0, 1'b0, 1'b1, v, it);
        check_eq("reverse_vid", 32'(v), 32'h1FF);
        check_eq("reverse_int", 32'(it), 32'd0);

        play(8'h41, 8'h00, 8'hFF, 5'd0, 1'b0, 1'b1, v, it);
        check_eq("blank_vid", 32'(v), 32'd0);

        play(8'h20, 8'h01, 8'h00, 5'd12, 1'b0, 1'b1, v, it);
        check_eq("ul_row12_vid", 32'(v), 32'h1FF);

        play(8'h20, 8'h01, 8'h00, 5'd11, 1'b0, 1'b1, v, it);
        check_eq("ul_row11_vid", 32'(v), 32'd0);

        play(8'h41, 8'h0F, 8'hFF, 5'd0, 1'b0, 1'b0, v, it);
        check_eq("disp_off_vid", 32'(v), 32'd0);
        check_eq("disp_off_int", 32'(it), 32'd0);

        // Second load coincides with the first cell's final dot.
        @(negedge clk);
        drive_cell(8'h44, 8'h07, 8'hF0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        bus.char_load = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            v2[17-i] = bus.video;
            if (i == 7) begin
                drive_cell(8'h41, 8'h07, 8'h0F, 5'd0, 1'b0, 1'b1);
            end else begin
                bus.char_load = 1'b0;
            end
        end
        check_eq("back2back_vid", 32'(v2), 32'(18'b111100000_000011110));

        bus.blink_en = 1'b1;
        play(8'h41, 8'h87, 8'h81, 5'd0, 1'b0, 1'b1, v, it);
        check_eq("blink_cnt0_vid", 32'(v), 32'(9'b100000010));
        vsync_pulses(8);
        play(8'h41, 8'h87, 8'h81, 5'd0, 1'b1, 1'b1, v, it);
        check_eq("cursor_cnt8_vid", 32'(v), 32'(9'b011111101));
        vsync_pulses(8);
        play(8'h41, 8'h87, 8'h81, 5'd0, 1'b0, 1'b1, v, it);
        check_eq("blink_cnt16_vid", 32'(v), 32'd0);
        vsync_pulses(16);
        play(8'h41, 8'h87, 8'h81, 5'd0, 1'b0, 1'b1, v, it);
        check_eq("blink_wrap_vid", 32'(v), 32'(9'b100000010));
        bus.blink_en = 1'b0;

        @(negedge clk);
        drive_cell(8'h20, 8'h78, 8'h00, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        bus.char_load = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_vid", 32'(bus.video), 32'd1);
        check_eq("pre_rst_int", 32'(bus.intensity), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_vid", 32'(bus.video), 32'd0);
        check_eq("mid_rst_int", 32'(bus.intensity), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_vid", 32'(bus.video), 32'd0);

        play(8'h41, 8'h07, 8'h81, 5'd0, 1'b0, 1'b1, v, it);
        check_eq("recover_vid", 32'(v), 32'(9'b100000010));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
